// File: rtl/sevseg_pkg.sv
// Shared constants and the hex-to-segment decoder for the 7-segment scan driver.
// Segment codes are active-low, bit 6 = g ... bit 0 = a.
package sevseg_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_ALL_ON = 7'h00;

    localparam logic [6:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        return SEG_CODES[nibble];
    endfunction

endpackage

// File: rtl/sevseg_scan_timer.sv
// Scan timing for the 7-segment driver: a prescaler that sets the length of
// each digit slot and a round-robin digit index. roundDone pulses for the
// single clock in which the last digit's slot ends and the index wraps to 0.
module sevseg_scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int PRE_W     = $clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             resetN,
    output logic [IDX_W-1:0] index,
    output logic             roundDone
);

    logic [PRE_W-1:0] prescaler_r;
    logic [IDX_W-1:0] index_r;
    logic             slotEnd_s;
    logic             lastDigit_s;

    assign slotEnd_s   = (prescaler_r == PRE_W'(SCAN_DIV - 1));
    assign lastDigit_s = (index_r == IDX_W'(NUM_DIGITS - 1));
    assign roundDone   = slotEnd_s & lastDigit_s;
    assign index       = index_r;

    // Advance the prescaler every clock and step the digit index at each slot end.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            prescaler_r <= {PRE_W{1'b0}};
            index_r     <= {IDX_W{1'b0}};
        end else begin
            if (slotEnd_s) begin
                prescaler_r <= {PRE_W{1'b0}};
                if (lastDigit_s) begin
                    index_r <= {IDX_W{1'b0}};
                end else begin
                    index_r <= index_r + 1'b1;
                end
            end else begin
                prescaler_r <= prescaler_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sevseg_scan_driver.sv
// Multiplexed common-anode 7-segment driver: latches a packed hex value on
// load, scans the digits round-robin and drives an active-low segment bus and
// active-low digit enables, with dark mode, lamp test and leading-zero
// blanking. Optional per-digit blinking is built when SEVSEG_BLINK_EN is defined.
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic                    darkN,
    input  logic                    LampTest,
    input  logic                    lzb_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              ss,
    output logic [NUM_DIGITS-1:0]   digit_selN
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] shadow_r;
    logic [6:0]              ss_r;
    logic [NUM_DIGITS-1:0]   digitSel_r;
    logic [IDX_W-1:0]        index_s;
    logic                    roundDone_s;
    logic [NUM_DIGITS-1:0]   lzbMask_s;
    logic [NUM_DIGITS-1:0]   blinkMask_s;
    logic [NUM_DIGITS-1:0]   scanSelN_s;
    logic                    zerosAbove_s;
    logic [3:0]              nibble_s;
    logic                    blanked_s;
    logic [6:0]              ssNext_s;
    logic [NUM_DIGITS-1:0]   selNext_s;

    sevseg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_timer (
        .clk       (clk),
        .resetN    (resetN),
        .index     (index_s),
        .roundDone (roundDone_s)
    );

    // Shadow register holding the displayed value; a load always wins.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            shadow_r <= {(4*NUM_DIGITS){1'b0}};
        end else if (load) begin
            shadow_r <= value_in;
        end
    end

`ifdef SEVSEG_BLINK_EN
    localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BC_W-1:0] blinkCnt_r;
    logic            blinkPhase_r;

    // Count full scan rounds and flip the blink phase every BLINK_DIV rounds.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            blinkCnt_r   <= {BC_W{1'b0}};
            blinkPhase_r <= 1'b0;
        end else if (roundDone_s) begin
            if (blinkCnt_r == BC_W'(BLINK_DIV - 1)) begin
                blinkCnt_r   <= {BC_W{1'b0}};
                blinkPhase_r <= ~blinkPhase_r;
            end else begin
                blinkCnt_r <= blinkCnt_r + 1'b1;
            end
        end
    end

    assign blinkMask_s = blinkPhase_r ? blink_mask : {NUM_DIGITS{1'b0}};
`else
    logic unusedBlink_s;

    // Without blinking the mask, round pulse and blink divider have no effect.
    assign unusedBlink_s = ^{blink_mask, roundDone_s, 32'(BLINK_DIV)};
    assign blinkMask_s   = {NUM_DIGITS{1'b0}};
`endif

    // Leading-zero mask: digit i > 0 goes dark when it and every higher nibble are zero.
    always_comb begin
        lzbMask_s    = {NUM_DIGITS{1'b0}};
        zerosAbove_s = lzb_en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zerosAbove_s = zerosAbove_s & (shadow_r[4*i +: 4] == 4'h0);
            lzbMask_s[i] = zerosAbove_s;
        end
    end

    // Pick the current digit's nibble, blank flag and one-hot-low enable.
    always_comb begin
        nibble_s   = 4'h0;
        blanked_s  = 1'b0;
        scanSelN_s = {NUM_DIGITS{1'b1}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index_s == IDX_W'(i)) begin
                nibble_s      = shadow_r[4*i +: 4];
                blanked_s     = lzbMask_s[i] | blinkMask_s[i];
                scanSelN_s[i] = 1'b0;
            end else begin
                scanSelN_s[i] = 1'b1;
            end
        end
    end

    // Output priority: dark, then lamp test, then the scanned digit.
    always_comb begin
        ssNext_s  = SEG_BLANK;
        selNext_s = {NUM_DIGITS{1'b1}};
        if (!darkN) begin
            ssNext_s  = SEG_BLANK;
            selNext_s = {NUM_DIGITS{1'b1}};
        end else if (LampTest) begin
            ssNext_s  = SEG_ALL_ON;
            selNext_s = {NUM_DIGITS{1'b0}};
        end else begin
            selNext_s = scanSelN_s;
            if (blanked_s) begin
                ssNext_s = SEG_BLANK;
            end else begin
                ssNext_s = seg_decode(nibble_s);
            end
        end
    end

    // Register the segment bus and digit enables.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            ss_r       <= SEG_BLANK;
            digitSel_r <= {NUM_DIGITS{1'b1}};
        end else begin
            ss_r       <= ssNext_s;
            digitSel_r <= selNext_s;
        end
    end

    assign ss         = ss_r;
    assign digit_selN = digitSel_r;

endmodule

// File: doc/sevseg_scan_driver.md
Name: sevseg_scan_driver

Overview:
Multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one active-low segment bus. It latches a packed hex value on a load strobe and scans the digits round-robin at a programmable rate. It supports dark (blank) mode, lamp test and leading-zero blanking. It replaces the per-digit combinational hex decoders on the display path of the score/timer units.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000, clocks per digit slot; minimum 2.
- BLINK_DIV, 64, full scan rounds per blink half-period; used only with SEVSEG_BLINK_EN.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous active-low reset.
- value_in  in  4*NUM_DIGITS  packed hex digits; nibble i drives digit i, digit 0 is least significant.
- load  in  1  one-cycle strobe; captures value_in.
- darkN  in  1  0 = whole display blank.
- LampTest  in  1  1 = all segments of all digits lit.
- lzb_en  in  1  1 = leading-zero blanking enabled.
- blink_mask  in  NUM_DIGITS  per-digit blink enable; ignored unless SEVSEG_BLINK_EN is defined.
- ss  out  7  segment bus, active-low, bit 6 = g … bit 0 = a.
- digit_selN  out  NUM_DIGITS  digit enables, active-low, one-hot-low while scanning.

Behaviour:
- Single clock domain (clk). All state resets synchronously while resetN = 0:
  - ss = 7'h7F
  - digit_selN = all ones
  - shadow value = 0
  - prescaler = 0
  - digit index = 0
- Load: if load = 1 on a clock edge, shadow <= value_in. A load overrides any concurrent scan event; the scan simply continues. Loads may arrive every cycle.
- Scan timing:
  - Prescaler counts 0..SCAN_DIV-1 and wraps to 0.
  - At prescaler == SCAN_DIV-1, index <= index+1, wrapping NUM_DIGITS-1 -> 0.
  - When NUM_DIGITS = 1 the index stays at 0.
- Outputs are registered and reflect the index, shadow and mode inputs sampled on the previous edge, i.e. 1 clock latency.
- Decode table, nibble -> ss:
  0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, B:03, C:46, D:21, E:06, F:0E.
- Output priority, evaluated per cycle:
  1. darkN = 0 -> ss = 7F, digit_selN = all ones.
  2. else LampTest = 1 -> ss = 00, digit_selN = all zeros (all digits on simultaneously).
  3. else digit_selN = ~(1 << index), ss = decode(shadow nibble[index]), unless that digit is blanked, in which case ss = 7F and digit_selN is still driven.
- Leading-zero blanking: with lzb_en = 1, digit i > 0 is blanked when nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked, so a value of 0 shows a single "0".
- Mode inputs take effect on the next registered output; the scan counters keep running in every mode.
- Reset mid-scan returns the display to digit 0 with a fresh prescaler after resetN rises.

Optional Feature:
- Macro: SEVSEG_BLINK_EN.
- Defined:
  - A blink counter increments on each index wrap (NUM_DIGITS-1 -> 0). After BLINK_DIV wraps it clears and toggles a blink phase bit; phase resets to 0 (visible).
  - While phase = 1, any digit with blink_mask[i] = 1 is blanked (ss = 7F).
  - darkN and LampTest still take priority over blink.
- Undefined: no blink counter is built; blink_mask is present but unused; behaviour is identical to the macro-defined build with blink_mask = 0.

Decomposition:
- Package sevseg_pkg:
  - SEG_CODES, a 16-entry array of 7-bit codes.
  - SEG_BLANK = 7'h7F and SEG_ALL_ON = 7'h00.
  - Function seg_decode(nibble).
- Sub-module sevseg_scan_timer: holds the prescaler and digit index and emits the index plus a round_done pulse on wrap. The top level owns the shadow register, blanking logic and output registers.

Test Plan:
- Reset with NUM_DIGITS = 4, SCAN_DIV = 4: hold resetN = 0 for 3 clocks -> ss = 7F, digit_selN = 4'hF. After release, the first slot shows digit 0, digit_selN = 4'hE.
- Load 16'h12AF, lzb_en = 0 -> successive slots give (digit_selN, ss) = (E,0E), (D,08), (B,24), (7,79); each slot lasts 4 clocks and the pattern repeats.
- Load 16'h0050, lzb_en = 1 -> digit0 shows 40, digit1 shows 12, digits 2 and 3 have ss = 7F. Load 16'h0000 -> only digit0 lit with 40.
- LampTest = 1 mid-slot -> next clock ss = 00, digit_selN = 0. Then darkN = 0 with LampTest still 1 -> ss = 7F, digit_selN = F.
- load asserted on the same edge as an index wrap, and resetN = 0 pulsed mid-slot -> the new value appears on the next visit to each digit; after reset, display restarts at digit 0 with a fresh prescaler.
- SEVSEG_BLINK_EN defined, BLINK_DIV = 2, blink_mask = 4'b0010 -> digit1 is blanked during rounds 2–3, visible during rounds 0–1 and 4–5; other digits are never blanked.
